// File: rtl/fuzz_log_pkg.sv
// Shared types and constants for the fuzzer result logger.
// Flag bits sit MSB->LSB as hang, crash, overflow inside every logged record.
package fuzz_log_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } log_state_t;

    localparam int FLG_OVF   = 0;
    localparam int FLG_CRASH = 1;
    localparam int FLG_HANG  = 2;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SEQ_WIDTH  = 16;

    // Record shape at the default widths; the top rebuilds it with its own parameters.
    typedef struct packed {
        logic [DEF_SEQ_WIDTH-1:0]  seq;
        logic [2:0]                flags;
        logic [3:0]                op;
        logic                      carry;
        logic [DEF_DATA_WIDTH-1:0] result;
    } fuzz_rec_t;

    function automatic logic [2:0] pack_flags(input logic crash, input logic hang,
                                              input logic ovf);
        logic [2:0] f;
        f            = '0;
        f[FLG_OVF]   = ovf;
        f[FLG_CRASH] = crash;
        f[FLG_HANG]  = hang;
        return f;
    endfunction

endpackage

// File: rtl/fuzz_log_fifo.sv
// First-word-fall-through FIFO for logged records with a synchronous flush.
// The storage array is not reset; only pointers and occupancy are.
module fuzz_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic                     o_rd_valid,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Caller guarantees push only when not full or when popping in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_valid = (r_level != '0);
    assign o_full     = (r_level == (AW+1)'(DEPTH));
    assign o_level    = r_level;
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fuzz_result_logger.sv
// Logs ALU fuzzer results: outcome statistics, a filtered record FIFO drained by a host,
// and an optional freeze after the first crash or hang to preserve the failing context.
module fuzz_result_logger
    import fuzz_log_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_DEPTH  = 16,
    parameter int SEQ_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               clear,
    input  logic                               filter_en,
    input  logic                               freeze_on_fail,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH:0]                in_result,
    input  logic [3:0]                         in_op,
    input  logic                               in_crash,
    input  logic                               in_hang,
    input  logic                               in_overflow,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [SEQ_WIDTH+8+DATA_WIDTH-1:0]  rd_data,
    output logic [$clog2(LOG_DEPTH):0]         level,
    output logic                               full,
    output logic                               frozen,
    output logic                               log_dropped,
    output logic [CNT_WIDTH-1:0]               tests_total,
    output logic [CNT_WIDTH-1:0]               crash_cnt,
    output logic [CNT_WIDTH-1:0]               hang_cnt,
    output logic [CNT_WIDTH-1:0]               ovf_cnt,
    output logic [CNT_WIDTH-1:0]               drop_cnt
);

    localparam int REC_W = SEQ_WIDTH + 8 + DATA_WIDTH;

    typedef struct packed {
        logic [SEQ_WIDTH-1:0]  seq;
        logic [2:0]            flags;
        logic [3:0]            op;
        logic                  carry;
        logic [DATA_WIDTH-1:0] result;
    } rec_t;

    log_state_t           r_state;
    log_state_t           w_state_next;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic [CNT_WIDTH-1:0] r_total;
    logic [CNT_WIDTH-1:0] r_crash;
    logic [CNT_WIDTH-1:0] r_hang;
    logic [CNT_WIDTH-1:0] r_ovf;
    logic [CNT_WIDTH-1:0] r_drop;
    logic                 r_dropped;

    logic w_accept;
    logic w_fail;
    logic w_qualify;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_full;
    logic w_rd_valid;
    rec_t w_rec;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // A clear pulse suppresses both the incoming event and any pop in that cycle.
    assign w_accept  = (r_state == RUN) && in_valid && !clear;
    assign w_fail    = in_crash || in_hang;
    assign w_qualify = !filter_en || in_crash || in_hang || in_overflow;
    assign w_pop     = w_rd_valid && rd_ready && !clear;
    assign w_push    = w_accept && w_qualify && (!w_full || w_pop);
    assign w_drop    = w_accept && w_qualify && w_full && !w_pop;

    always_comb begin
        w_rec        = '0;
        w_rec.seq    = r_seq;
        w_rec.flags  = pack_flags(in_crash, in_hang, in_overflow);
        w_rec.op     = in_op;
        w_rec.carry  = in_result[DATA_WIDTH];
        w_rec.result = in_result[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A failing event freezes even if enable drops in the same cycle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_accept && w_fail && freeze_on_fail) begin
                    w_state_next = FROZEN;
                end else if (!enable) begin
                    w_state_next = IDLE;
                end
            end
            FROZEN: begin
                w_state_next = FROZEN;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (clear) begin
            w_state_next = enable ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_seq     <= '0;
            r_total   <= '0;
            r_crash   <= '0;
            r_hang    <= '0;
            r_ovf     <= '0;
            r_drop    <= '0;
            r_dropped <= 1'b0;
        end else begin
            if (w_accept) begin
                r_seq <= r_seq + 1'b1;
            end
            r_total <= sat_inc(r_total, w_accept);
            r_crash <= sat_inc(r_crash, w_accept && in_crash);
            r_hang  <= sat_inc(r_hang,  w_accept && in_hang);
            r_ovf   <= sat_inc(r_ovf,   w_accept && in_overflow);
            r_drop  <= sat_inc(r_drop,  w_drop);
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
        end
    end

    fuzz_log_fifo #(
        .WIDTH (REC_W),
        .DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (clear),
        .i_push     (w_push),
        .i_wr_data  (w_rec),
        .i_pop      (w_pop),
        .o_rd_valid (w_rd_valid),
        .o_rd_data  (rd_data),
        .o_level    (level),
        .o_full     (w_full)
    );

    assign rd_valid    = w_rd_valid;
    assign full        = w_full;
    assign frozen      = (r_state == FROZEN);
    assign log_dropped = r_dropped;
    assign tests_total = r_total;
    assign crash_cnt   = r_crash;
    assign hang_cnt    = r_hang;
    assign ovf_cnt     = r_ovf;
    assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_fuzz_result_logger.sv
// Directed and randomized checks of fuzz_result_logger against a queue-based reference model.
// A second, narrow instance covers counter saturation and sequence wrap.
module tb_fuzz_result_logger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, clear, filter_en, freeze_on_fail, in_valid;
    logic [32:0] in_result;
    logic [3:0]  in_op;
    logic        in_crash, in_hang, in_overflow, rd_ready;

    logic        a_rd_valid, a_full, a_frozen, a_log_dropped;
    logic [55:0] a_rd_data;
    logic [4:0]  a_level;
    logic [15:0] a_tests_total, a_crash_cnt, a_hang_cnt, a_ovf_cnt, a_drop_cnt;

    logic        b_rd_valid, b_full, b_frozen, b_log_dropped;
    logic [43:0] b_rd_data;
    logic [2:0]  b_level;
    logic [3:0]  b_tests_total, b_crash_cnt, b_hang_cnt, b_ovf_cnt, b_drop_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queue plus integer statistics.
    logic [55:0] mq[$];
    int          mState;
    logic [15:0] mSeq;
    int          mTotal, mCrash, mHang, mOvf, mDrop;
    bit          mDropped;

    always #5 clk = ~clk;

    fuzz_result_logger dutA (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .filter_en(filter_en),
        .freeze_on_fail(freeze_on_fail), .in_valid(in_valid), .in_result(in_result),
        .in_op(in_op), .in_crash(in_crash), .in_hang(in_hang), .in_overflow(in_overflow),
        .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_data(a_rd_data), .level(a_level),
        .full(a_full), .frozen(a_frozen), .log_dropped(a_log_dropped),
        .tests_total(a_tests_total), .crash_cnt(a_crash_cnt), .hang_cnt(a_hang_cnt),
        .ovf_cnt(a_ovf_cnt), .drop_cnt(a_drop_cnt)
    );

    fuzz_result_logger #(
        .DATA_WIDTH(32), .LOG_DEPTH(4), .SEQ_WIDTH(4), .CNT_WIDTH(4)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .filter_en(filter_en),
        .freeze_on_fail(freeze_on_fail), .in_valid(in_valid), .in_result(in_result),
        .in_op(in_op), .in_crash(in_crash), .in_hang(in_hang), .in_overflow(in_overflow),
        .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_data(b_rd_data), .level(b_level),
        .full(b_full), .frozen(b_frozen), .log_dropped(b_log_dropped),
        .tests_total(b_tests_total), .crash_cnt(b_crash_cnt), .hang_cnt(b_hang_cnt),
        .ovf_cnt(b_ovf_cnt), .drop_cnt(b_drop_cnt)
    );

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [32:0] rndRes();
        logic [32:0] r;
        r = {1'($urandom), 32'($urandom)};
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mState   = 0;
        mSeq     = '0;
        mTotal   = 0;
        mCrash   = 0;
        mHang    = 0;
        mOvf     = 0;
        mDrop    = 0;
        mDropped = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        logic [55:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        checkOutput({tag, ":rd_valid"},    64'(a_rd_valid),    64'(mq.size() != 0));
        checkOutput({tag, ":rd_data"},     64'(a_rd_data),     64'(head));
        checkOutput({tag, ":level"},       64'(a_level),       64'(mq.size()));
        checkOutput({tag, ":full"},        64'(a_full),        64'(mq.size() == 16));
        checkOutput({tag, ":frozen"},      64'(a_frozen),      64'(mState == 2));
        checkOutput({tag, ":log_dropped"}, 64'(a_log_dropped), 64'(mDropped));
        checkOutput({tag, ":tests_total"}, 64'(a_tests_total), 64'(sat16(mTotal)));
        checkOutput({tag, ":crash_cnt"},   64'(a_crash_cnt),   64'(sat16(mCrash)));
        checkOutput({tag, ":hang_cnt"},    64'(a_hang_cnt),    64'(sat16(mHang)));
        checkOutput({tag, ":ovf_cnt"},     64'(a_ovf_cnt),     64'(sat16(mOvf)));
        checkOutput({tag, ":drop_cnt"},    64'(a_drop_cnt),    64'(sat16(mDrop)));
    endtask

    task automatic doReset();
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; filter_en = 1'b0; freeze_on_fail = 1'b0;
        in_valid = 1'b0; in_result = '0; in_op = '0; in_crash = 1'b0; in_hang = 1'b0;
        in_overflow = 1'b0; rd_ready = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; enable/filter_en/freeze_on_fail are held by the caller.
    task automatic applyStimulus(input bit vld, input logic [32:0] res, input logic [3:0] op,
                                 input bit cr, input bit hg, input bit ov,
                                 input bit rdy, input bit clr);
        bit          popNow;
        bit          acc;
        logic [55:0] rec;
        in_valid = vld; in_result = res; in_op = op; in_crash = cr; in_hang = hg;
        in_overflow = ov; rd_ready = rdy; clear = clr;
        popNow = (mq.size() != 0) && rdy && !clr;
        if (clr) begin
            modelReset();
            mState = enable ? 1 : 0;
        end else begin
            acc = (mState == 1) && vld;
            if (popNow) void'(mq.pop_front());
            if (acc) begin
                mTotal++;
                if (cr) mCrash++;
                if (hg) mHang++;
                if (ov) mOvf++;
                rec  = {mSeq, hg, cr, ov, op, res};
                mSeq = mSeq + 16'd1;
                if (!filter_en || cr || hg || ov) begin
                    if (mq.size() < 16) mq.push_back(rec);
                    else begin
                        mDrop++;
                        mDropped = 1'b1;
                    end
                end
            end
            if (mState == 0 && enable) mState = 1;
            else if (mState == 1) begin
                if (acc && (cr || hg) && freeze_on_fail) mState = 2;
                else if (!enable) mState = 0;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        logic [32:0] basicRes [3];
        logic [32:0] r;
        logic [3:0]  op;
        logic [43:0] expB;

        $display("[TB] start");
        doReset();
        checkAll("reset");

        // Basic logging
        basicRes[0] = 33'h0_0000_0005;
        basicRes[1] = 33'h0_FFFF_FFFF;
        basicRes[2] = 33'h0_0000_0000;
        enable = 1'b1;
        applyStimulus(0, '0, '0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, basicRes[i], 4'(i + 3), 0, 0, 0, 0, 0);
            checkAll("basic_ev");
        end
        checkOutput("basic_total", 64'(a_tests_total), 64'd3);
        checkOutput("basic_level", 64'(a_level), 64'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("basic_rd_seq", 64'(a_rd_data[55:40]), 64'(i));
            checkOutput("basic_rd_res", 64'(a_rd_data[32:0]), 64'(basicRes[i]));
            applyStimulus(0, '0, '0, 0, 0, 0, 1, 0);
            checkAll("basic_drain");
        end

        // Filter
        filter_en = 1'b1;
        applyStimulus(0, '0, '0, 0, 0, 0, 0, 1);
        checkAll("filter_clear");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, rndRes(), 4'($urandom), (i == 2), 0, 0, 0, 0);
            checkAll("filter_ev");
        end
        checkOutput("filter_total", 64'(a_tests_total), 64'd4);
        checkOutput("filter_crash", 64'(a_crash_cnt), 64'd1);
        checkOutput("filter_level", 64'(a_level), 64'd1);
        checkOutput("filter_seq", 64'(a_rd_data[55:40]), 64'd2);
        checkOutput("filter_crashbit", 64'(a_rd_data[38]), 64'd1);

        // Full and drop
        filter_en = 1'b0;
        applyStimulus(0, '0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1, rndRes(), 4'($urandom), 0, 0, 1'($urandom), 0, 0);
            checkAll("full_ev");
        end
        checkOutput("full_flag", 64'(a_full), 64'd1);
        checkOutput("full_level", 64'(a_level), 64'd16);
        checkOutput("full_drop_cnt", 64'(a_drop_cnt), 64'd2);
        checkOutput("full_log_dropped", 64'(a_log_dropped), 64'd1);
        applyStimulus(1, rndRes(), 4'($urandom), 0, 0, 0, 1, 0);
        checkOutput("full_pop_push_level", 64'(a_level), 64'd16);
        checkOutput("full_pop_push_drop", 64'(a_drop_cnt), 64'd2);
        checkAll("full_pop_push");

        // Freeze
        freeze_on_fail = 1'b1;
        applyStimulus(0, '0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, rndRes(), 4'($urandom), 0, (i == 5), 0, 1, 0);
            checkAll("freeze_ev");
        end
        checkOutput("freeze_frozen", 64'(a_frozen), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, rndRes(), 4'($urandom), 1, 0, 0, 0, 0);
            checkAll("freeze_ignored");
        end
        checkOutput("freeze_total_held", 64'(a_tests_total), 64'd6);
        applyStimulus(0, '0, '0, 0, 0, 0, 0, 1);
        checkOutput("freeze_clear_frozen", 64'(a_frozen), 64'd0);
        checkOutput("freeze_clear_total", 64'(a_tests_total), 64'd0);
        checkOutput("freeze_clear_level", 64'(a_level), 64'd0);
        applyStimulus(1, rndRes(), 4'($urandom), 0, 0, 0, 0, 0);
        checkOutput("freeze_run_again", 64'(a_tests_total), 64'd1);
        checkAll("freeze_after");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            enable         = ($urandom_range(0, 9) != 0);
            filter_en      = 1'($urandom);
            freeze_on_fail = ($urandom_range(0, 4) == 0);
            applyStimulus(($urandom_range(0, 9) < 6), rndRes(), 4'($urandom),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) < 2), 1'($urandom),
                          ($urandom_range(0, 39) == 0));
            checkAll("random");
        end

        // Reset mid-stream
        enable = 1'b1; filter_en = 1'b0; freeze_on_fail = 1'b0;
        applyStimulus(0, '0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, rndRes(), 4'($urandom), 0, 0, 0, 0, 0);
        end
        checkOutput("rst_pre_level", 64'(a_level), 64'd5);
        doReset();
        checkOutput("rst_rd_valid", 64'(a_rd_valid), 64'd0);
        checkOutput("rst_level", 64'(a_level), 64'd0);
        checkAll("rst_mid");

        // Saturation and sequence wrap on the narrow instance
        enable = 1'b1;
        applyStimulus(0, '0, '0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            r  = rndRes();
            op = 4'($urandom);
            applyStimulus(1, r, op, 0, 0, 0, 1, 0);
            expB = {4'(i % 16), 3'b000, op, r};
            checkOutput("wrap_rd_valid", 64'(b_rd_valid), 64'd1);
            checkOutput("wrap_rd_data", 64'(b_rd_data), 64'(expB));
        end
        checkOutput("sat_total", 64'(b_tests_total), 64'd15);
        checkOutput("sat_drop", 64'(b_drop_cnt), 64'd0);
        checkOutput("sat_level", 64'(b_level), 64'd1);
        checkAll("sat_dutA");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
